// File: rtl/seg_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_controller
// Brief    : Time-multiplexed scan controller for a 4-digit common-anode
//            7-segment display with a double-buffered value and load/ack.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_controller #(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] num_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    input  logic        load,
    output logic        load_ack,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int c_cnt_max = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
    localparam logic [c_cnt_w-1:0] c_digit_last = c_cnt_w'(DIGIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_blank_last =
        (BLANK_CYCLES > 0) ? c_cnt_w'(BLANK_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    state_t               r_state;
    logic [1:0]           r_idx;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [15:0]          r_disp_num;
    logic [3:0]           r_disp_dp;
    logic [15:0]          r_pend_num;
    logic [3:0]           r_pend_dp;
    logic                 r_pend_full;
    logic [6:0]           r_seg;
    logic                 r_dp;
    logic [3:0]           r_an;
    logic                 r_load_ack;
    logic                 r_frame_tick;

    logic                 w_digit_end;
    logic                 w_blank_end;
    logic                 w_boundary;
    logic                 w_swap;
    logic                 w_accept;
    logic [3:0]           w_nib;
    logic                 w_upper_zero;
    logic                 w_suppress;
    logic [6:0]           w_seg_code;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0:    code = 7'b1000000;
            4'h1:    code = 7'b1111001;
            4'h2:    code = 7'b0100100;
            4'h3:    code = 7'b0110000;
            4'h4:    code = 7'b0011001;
            4'h5:    code = 7'b0010010;
            4'h6:    code = 7'b0000010;
            4'h7:    code = 7'b1111000;
            4'h8:    code = 7'b0000000;
            4'h9:    code = 7'b0010000;
            default: code = 7'b0000001;
        endcase
        return code;
    endfunction

    always_comb begin
        w_digit_end = (r_state == ST_SHOW)  && (r_cnt == c_digit_last);
        w_blank_end = (r_state == ST_BLANK) && (r_cnt == c_blank_last);
        // The frame ends on the last cycle of digit 3's slot, whichever phase closes it.
        w_boundary  = (r_idx == 2'd3) && ((BLANK_CYCLES > 0) ? w_blank_end : w_digit_end);
        w_swap      = r_pend_full && (w_boundary || (r_state == ST_OFF));
        w_accept    = load && (!r_pend_full || w_swap);
        w_nib       = r_disp_num[{r_idx, 2'b00} +: 4];
        case (r_idx)
            2'd1:    w_upper_zero = (r_disp_num[15:4]  == 12'd0);
            2'd2:    w_upper_zero = (r_disp_num[15:8]  == 8'd0);
            2'd3:    w_upper_zero = (r_disp_num[15:12] == 4'd0);
            default: w_upper_zero = 1'b0;
        endcase
        w_suppress  = blank_lz && w_upper_zero;
        w_seg_code  = seg_decode(w_nib);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_OFF;
            r_idx        <= 2'd0;
            r_cnt        <= '0;
            r_disp_num   <= 16'd0;
            r_disp_dp    <= 4'd0;
            r_pend_num   <= 16'd0;
            r_pend_dp    <= 4'd0;
            r_pend_full  <= 1'b0;
            r_seg        <= 7'h7F;
            r_dp         <= 1'b1;
            r_an         <= 4'hF;
            r_load_ack   <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_boundary;
            r_load_ack   <= w_accept;

            // Display takes the old pending value before a same-cycle load overwrites it.
            if (w_swap) begin
                r_disp_num <= r_pend_num;
                r_disp_dp  <= r_pend_dp;
            end
            if (w_accept) begin
                r_pend_num  <= num_in;
                r_pend_dp   <= dp_in;
                r_pend_full <= 1'b1;
            end else if (w_swap) begin
                r_pend_full <= 1'b0;
            end

            if (enable && (r_state == ST_SHOW) && !w_suppress) begin
                r_an  <= ~(4'b0001 << r_idx);
                r_seg <= w_seg_code;
                r_dp  <= ~r_disp_dp[r_idx];
            end else begin
                r_an  <= 4'hF;
                r_seg <= 7'h7F;
                r_dp  <= 1'b1;
            end

            if (!enable) begin
                r_state <= ST_OFF;
                r_idx   <= 2'd0;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    ST_OFF: begin
                        r_state <= ST_SHOW;
                        r_idx   <= 2'd0;
                        r_cnt   <= '0;
                    end
                    ST_SHOW: begin
                        if (w_digit_end) begin
                            r_cnt <= '0;
                            if (BLANK_CYCLES > 0) begin
                                r_state <= ST_BLANK;
                            end else begin
                                r_idx <= r_idx + 2'd1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_BLANK: begin
                        if (w_blank_end) begin
                            r_cnt   <= '0;
                            r_idx   <= r_idx + 2'd1;
                            r_state <= ST_SHOW;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_OFF;
                        r_idx   <= 2'd0;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign load_ack   = r_load_ack;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire
